// File: rtl/rob_multi.sv
// Multi-issue reorder buffer: allocates up to DISP_W tags per cycle from the
// tail, marks entries done from NUM_CDB completion ports, retires up to
// COMMIT_W finished entries per cycle in order from the head, and on a
// mispredict squashes only the entries younger than the offending branch.
module rob_multi #(
  parameter int ROB_WIDTH  = 4,
  parameter int PREG_WIDTH = 7,
  parameter int DISP_W     = 2,
  parameter int COMMIT_W   = 2,
  parameter int NUM_CDB    = 2
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [DISP_W-1:0]               i_alloc_valid,
  input  logic [DISP_W*PREG_WIDTH-1:0]    i_alloc_old_prd,
  input  logic [DISP_W-1:0]               i_alloc_is_branch,
  input  logic [DISP_W*32-1:0]            i_alloc_pc,
  output logic                            o_alloc_ready,
  output logic [DISP_W*ROB_WIDTH-1:0]     o_alloc_tag,
  input  logic [NUM_CDB-1:0]              i_cdb_valid,
  input  logic [NUM_CDB*ROB_WIDTH-1:0]    i_cdb_tag,
  output logic [COMMIT_W-1:0]             o_commit_valid,
  output logic [COMMIT_W*PREG_WIDTH-1:0]  o_commit_old_preg,
  output logic [COMMIT_W*ROB_WIDTH-1:0]   o_commit_tag,
  output logic [COMMIT_W*32-1:0]          o_commit_pc,
  input  logic                            i_flush_valid,
  input  logic [ROB_WIDTH-1:0]            i_flush_tag,
  output logic [ROB_WIDTH:0]              o_count,
  output logic                            o_empty
);

  localparam int ROB_SIZE = 1 << ROB_WIDTH;

  logic [ROB_WIDTH-1:0]  head;
  logic [ROB_WIDTH-1:0]  tail;
  logic [ROB_WIDTH:0]    count;
  logic [ROB_SIZE-1:0]   ent_valid;
  logic [ROB_SIZE-1:0]   ent_done;
  logic [PREG_WIDTH-1:0] ent_preg [ROB_SIZE];
  logic [31:0]           ent_pc   [ROB_SIZE];

  logic                  alloc_fire;
  logic [ROB_WIDTH:0]    num_alloc;
  logic [ROB_WIDTH:0]    num_commit;
  logic                  commit_chain;
  logic [ROB_WIDTH-1:0]  commit_idx;
  logic                  flush_hit;
  logic [ROB_WIDTH-1:0]  flush_dist;
  logic [ROB_WIDTH-1:0]  rel_age;
  logic [ROB_SIZE-1:0]   squash;

  // The branch flag is carried for interface compatibility; recovery is
  // driven purely by the flush tag, so nothing inside consumes it.
  logic unused_is_branch;
  assign unused_is_branch = ^i_alloc_is_branch;

  assign o_count = count;
  assign o_empty = (count == '0);

  // Allocation readiness, group size and the tags each slot would receive.
  always_comb begin
    o_alloc_ready = (count <= (ROB_WIDTH+1)'(ROB_SIZE - DISP_W));
    alloc_fire    = o_alloc_ready && !i_flush_valid;
    num_alloc     = '0;
    o_alloc_tag   = '0;
    for (int k = 0; k < DISP_W; k++) begin
      num_alloc = num_alloc + {{ROB_WIDTH{1'b0}}, i_alloc_valid[k]};
      o_alloc_tag[k*ROB_WIDTH +: ROB_WIDTH] = tail + ROB_WIDTH'(k);
    end
  end

  // In-order retirement window: slot k commits only if every older slot does.
  always_comb begin
    commit_chain      = 1'b1;
    commit_idx        = '0;
    num_commit        = '0;
    o_commit_valid    = '0;
    o_commit_tag      = '0;
    o_commit_old_preg = '0;
    o_commit_pc       = '0;
    for (int k = 0; k < COMMIT_W; k++) begin
      commit_idx   = head + ROB_WIDTH'(k);
      commit_chain = commit_chain && ((ROB_WIDTH+1)'(k) < count) &&
                     ent_valid[commit_idx] && ent_done[commit_idx];
      o_commit_valid[k] = commit_chain;
      o_commit_tag[k*ROB_WIDTH +: ROB_WIDTH]        = commit_idx;
      o_commit_old_preg[k*PREG_WIDTH +: PREG_WIDTH] = ent_preg[commit_idx];
      o_commit_pc[k*32 +: 32]                       = ent_pc[commit_idx];
      num_commit = num_commit + {{ROB_WIDTH{1'b0}}, commit_chain};
    end
  end

  // Squash mask: every entry whose age relative to head exceeds the branch's.
  always_comb begin
    flush_hit  = i_flush_valid && ent_valid[i_flush_tag];
    flush_dist = i_flush_tag - head;
    rel_age    = '0;
    squash     = '0;
    for (int i = 0; i < ROB_SIZE; i++) begin
      rel_age   = ROB_WIDTH'(i) - head;
      squash[i] = flush_hit && (rel_age > flush_dist);
    end
  end

  // Pointer, occupancy and per-entry status update; later writes win, so a
  // squash overrides a same-cycle completion on a younger entry.
  always_ff @(posedge clk) begin
    if (reset) begin
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      ent_valid <= '0;
      ent_done  <= '0;
    end else begin
      for (int p = 0; p < NUM_CDB; p++) begin
        if (i_cdb_valid[p] && ent_valid[i_cdb_tag[p*ROB_WIDTH +: ROB_WIDTH]])
          ent_done[i_cdb_tag[p*ROB_WIDTH +: ROB_WIDTH]] <= 1'b1;
      end
      for (int k = 0; k < COMMIT_W; k++) begin
        if (o_commit_valid[k]) begin
          ent_valid[head + ROB_WIDTH'(k)] <= 1'b0;
          ent_done[head + ROB_WIDTH'(k)]  <= 1'b0;
        end
      end
      for (int k = 0; k < DISP_W; k++) begin
        if (alloc_fire && i_alloc_valid[k]) begin
          ent_valid[tail + ROB_WIDTH'(k)] <= 1'b1;
          ent_done[tail + ROB_WIDTH'(k)]  <= 1'b0;
        end
      end
      for (int i = 0; i < ROB_SIZE; i++) begin
        if (squash[i]) begin
          ent_valid[i] <= 1'b0;
          ent_done[i]  <= 1'b0;
        end
      end
      head <= head + num_commit[ROB_WIDTH-1:0];
      if (flush_hit) begin
        tail  <= i_flush_tag + 1'b1;
        count <= {1'b0, flush_dist} + 1'b1 - num_commit;
      end else if (alloc_fire) begin
        tail  <= tail + num_alloc[ROB_WIDTH-1:0];
        count <= count + num_alloc - num_commit;
      end else begin
        count <= count - num_commit;
      end
    end
  end

  // Entry payload captured at allocation; it is only read while valid.
  always_ff @(posedge clk) begin
    for (int k = 0; k < DISP_W; k++) begin
      if (alloc_fire && i_alloc_valid[k]) begin
        ent_preg[tail + ROB_WIDTH'(k)] <= i_alloc_old_prd[k*PREG_WIDTH +: PREG_WIDTH];
        ent_pc[tail + ROB_WIDTH'(k)]   <= i_alloc_pc[k*32 +: 32];
      end
    end
  end

endmodule

// File: tb/tb_rob_multi.sv
// Directed bench for rob_multi: fill/full, completion and commit, pointer
// wrap, partial flush with commit, flush racing alloc/CDB, invalid flush and
// reset during a flush.
module tb_rob_multi;

  logic        clk;
  logic        reset;
  logic [1:0]  i_alloc_valid;
  logic [13:0] i_alloc_old_prd;
  logic [1:0]  i_alloc_is_branch;
  logic [63:0] i_alloc_pc;
  logic        o_alloc_ready;
  logic [7:0]  o_alloc_tag;
  logic [1:0]  i_cdb_valid;
  logic [7:0]  i_cdb_tag;
  logic [1:0]  o_commit_valid;
  logic [13:0] o_commit_old_preg;
  logic [7:0]  o_commit_tag;
  logic [63:0] o_commit_pc;
  logic        i_flush_valid;
  logic [3:0]  i_flush_tag;
  logic [4:0]  o_count;
  logic        o_empty;

  int total = 0;
  int bad   = 0;

  rob_multi #(.ROB_WIDTH(4), .PREG_WIDTH(7), .DISP_W(2), .COMMIT_W(2), .NUM_CDB(2)) dut (
    .clk(clk), .reset(reset),
    .i_alloc_valid(i_alloc_valid), .i_alloc_old_prd(i_alloc_old_prd),
    .i_alloc_is_branch(i_alloc_is_branch), .i_alloc_pc(i_alloc_pc),
    .o_alloc_ready(o_alloc_ready), .o_alloc_tag(o_alloc_tag),
    .i_cdb_valid(i_cdb_valid), .i_cdb_tag(i_cdb_tag),
    .o_commit_valid(o_commit_valid), .o_commit_old_preg(o_commit_old_preg),
    .o_commit_tag(o_commit_tag), .o_commit_pc(o_commit_pc),
    .i_flush_valid(i_flush_valid), .i_flush_tag(i_flush_tag),
    .o_count(o_count), .o_empty(o_empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clear_inputs();
    i_alloc_valid     = '0;
    i_alloc_old_prd   = '0;
    i_alloc_is_branch = '0;
    i_alloc_pc        = '0;
    i_cdb_valid       = '0;
    i_cdb_tag         = '0;
    i_flush_valid     = 1'b0;
    i_flush_tag       = '0;
  endtask

  // One clock; outputs are then sampled and inputs changed 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Allocate a pair whose old preg is base+tag and pc is 0x100+4*tag.
  task automatic drive_alloc(input int t0, input int base);
    i_alloc_valid   = 2'b11;
    i_alloc_old_prd = {7'(base + t0 + 1), 7'(base + t0)};
    i_alloc_pc      = {32'(256 + 4*(t0 + 1)), 32'(256 + 4*t0)};
  endtask

  task automatic drive_cdb(input logic [1:0] v, input int t1, input int t0);
    i_cdb_valid = v;
    i_cdb_tag   = {4'(t1), 4'(t0)};
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (o_count !== 5'd0) begin bad++; $display("[TB] FAIL reset_count got=%0d want=0", o_count); end
    total++; if (o_empty !== 1'b1) begin bad++; $display("[TB] FAIL reset_empty got=%b want=1", o_empty); end
    total++; if (o_alloc_ready !== 1'b1) begin bad++; $display("[TB] FAIL reset_ready got=%b want=1", o_alloc_ready); end
    total++; if (o_commit_valid !== 2'b00) begin bad++; $display("[TB] FAIL reset_cvalid got=%b want=00", o_commit_valid); end
    total++; if (o_alloc_tag !== 8'h10) begin bad++; $display("[TB] FAIL reset_atag got=%h want=10", o_alloc_tag); end
    total++; if (o_commit_tag !== 8'h10) begin bad++; $display("[TB] FAIL reset_ctag got=%h want=10", o_commit_tag); end
  endtask

  task automatic test_fill();
    for (int i = 0; i < 8; i++) begin
      total++;
      if (o_alloc_tag !== {4'(2*i+1), 4'(2*i)}) begin
        bad++; $display("[TB] FAIL fill_tag%0d got=%h want=%h", i, o_alloc_tag, {4'(2*i+1), 4'(2*i)});
      end
      total++; if (o_alloc_ready !== 1'b1) begin bad++; $display("[TB] FAIL fill_ready%0d got=%b want=1", i, o_alloc_ready); end
      drive_alloc(2*i, 10);
      tick();
    end
    total++; if (o_count !== 5'd16) begin bad++; $display("[TB] FAIL full_count got=%0d want=16", o_count); end
    total++; if (o_alloc_ready !== 1'b0) begin bad++; $display("[TB] FAIL full_ready got=%b want=0", o_alloc_ready); end
    drive_alloc(0, 90);
    tick();
    clear_inputs();
    total++; if (o_count !== 5'd16) begin bad++; $display("[TB] FAIL full_drop_count got=%0d want=16", o_count); end
    total++; if (o_alloc_tag !== 8'h10) begin bad++; $display("[TB] FAIL full_drop_tag got=%h want=10", o_alloc_tag); end
  endtask

  task automatic test_commit();
    drive_cdb(2'b01, 0, 1);
    tick();
    clear_inputs();
    total++; if (o_commit_valid !== 2'b00) begin bad++; $display("[TB] FAIL out_of_order got=%b want=00", o_commit_valid); end
    drive_cdb(2'b11, 0, 1);
    tick();
    clear_inputs();
    total++; if (o_commit_valid !== 2'b11) begin bad++; $display("[TB] FAIL commit2_valid got=%b want=11", o_commit_valid); end
    total++; if (o_commit_tag !== 8'h10) begin bad++; $display("[TB] FAIL commit2_tag got=%h want=10", o_commit_tag); end
    total++; if (o_commit_old_preg !== {7'd11, 7'd10}) begin bad++; $display("[TB] FAIL commit2_preg got=%h want=%h", o_commit_old_preg, {7'd11, 7'd10}); end
    total++; if (o_commit_pc !== {32'h104, 32'h100}) begin bad++; $display("[TB] FAIL commit2_pc got=%h want=%h", o_commit_pc, {32'h104, 32'h100}); end
    total++; if (o_alloc_ready !== 1'b0) begin bad++; $display("[TB] FAIL full_while_commit got=%b want=0", o_alloc_ready); end
    tick();
    total++; if (o_count !== 5'd14) begin bad++; $display("[TB] FAIL after_commit_count got=%0d want=14", o_count); end
    total++; if (o_alloc_ready !== 1'b1) begin bad++; $display("[TB] FAIL after_commit_ready got=%b want=1", o_alloc_ready); end
    total++; if (o_commit_tag !== 8'h32) begin bad++; $display("[TB] FAIL after_commit_ctag got=%h want=32", o_commit_tag); end
  endtask

  task automatic test_wrap();
    do_reset();
    for (int i = 0; i < 7; i++) begin
      drive_alloc(2*i, 0);
      tick();
      clear_inputs();
      drive_cdb(2'b11, 2*i+1, 2*i);
      tick();
      clear_inputs();
    end
    tick();
    total++; if (o_empty !== 1'b1) begin bad++; $display("[TB] FAIL wrap_pre_empty got=%b want=1", o_empty); end
    total++; if (o_alloc_tag !== 8'hFE) begin bad++; $display("[TB] FAIL wrap_atag0 got=%h want=fe", o_alloc_tag); end
    drive_alloc(14, 30);
    tick();
    total++; if (o_alloc_tag !== 8'h10) begin bad++; $display("[TB] FAIL wrap_atag1 got=%h want=10", o_alloc_tag); end
    i_alloc_valid   = 2'b11;
    i_alloc_old_prd = {7'd31, 7'd30};
    i_alloc_pc      = {32'h204, 32'h200};
    tick();
    clear_inputs();
    total++; if (o_count !== 5'd4) begin bad++; $display("[TB] FAIL wrap_count got=%0d want=4", o_count); end
    drive_cdb(2'b11, 15, 14);
    tick();
    drive_cdb(2'b11, 1, 0);
    total++; if (o_commit_tag !== 8'hFE || o_commit_valid !== 2'b11) begin
      bad++; $display("[TB] FAIL wrap_commitA got=%h/%b want=fe/11", o_commit_tag, o_commit_valid);
    end
    tick();
    clear_inputs();
    total++; if (o_commit_tag !== 8'h10 || o_commit_valid !== 2'b11) begin
      bad++; $display("[TB] FAIL wrap_commitB got=%h/%b want=10/11", o_commit_tag, o_commit_valid);
    end
    total++; if (o_commit_old_preg !== {7'd31, 7'd30}) begin bad++; $display("[TB] FAIL wrap_preg got=%h want=%h", o_commit_old_preg, {7'd31, 7'd30}); end
    tick();
    total++; if (o_empty !== 1'b1 || o_count !== 5'd0) begin bad++; $display("[TB] FAIL wrap_drain got=%b/%0d want=1/0", o_empty, o_count); end
    total++; if (o_commit_tag !== 8'h32) begin bad++; $display("[TB] FAIL wrap_head got=%h want=32", o_commit_tag); end
  endtask

  task automatic test_flush_commit();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drive_alloc(2*i, 50);
      tick();
    end
    clear_inputs();
    drive_cdb(2'b01, 0, 0);
    tick();
    clear_inputs();
    total++; if (o_commit_valid !== 2'b01) begin bad++; $display("[TB] FAIL fc_pre_commit got=%b want=01", o_commit_valid); end
    i_flush_valid = 1'b1;
    i_flush_tag   = 4'd4;
    tick();
    clear_inputs();
    total++; if (o_count !== 5'd4) begin bad++; $display("[TB] FAIL fc_count got=%0d want=4", o_count); end
    total++; if (o_alloc_tag !== 8'h65) begin bad++; $display("[TB] FAIL fc_atag got=%h want=65", o_alloc_tag); end
    total++; if (o_commit_tag !== 8'h21) begin bad++; $display("[TB] FAIL fc_ctag got=%h want=21", o_commit_tag); end
    drive_cdb(2'b01, 0, 7);
    tick();
    clear_inputs();
    total++; if (o_count !== 5'd4 || o_commit_valid !== 2'b00) begin
      bad++; $display("[TB] FAIL fc_cdb_squashed got=%0d/%b want=4/00", o_count, o_commit_valid);
    end
    drive_cdb(2'b11, 2, 1);
    tick();
    clear_inputs();
    total++; if (o_commit_valid !== 2'b11 || o_commit_old_preg !== {7'd52, 7'd51}) begin
      bad++; $display("[TB] FAIL fc_survivor got=%b/%h want=11/%h", o_commit_valid, o_commit_old_preg, {7'd52, 7'd51});
    end
    tick();
    total++; if (o_count !== 5'd2) begin bad++; $display("[TB] FAIL fc_after got=%0d want=2", o_count); end
  endtask

  task automatic test_flush_alloc_cdb();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive_alloc(2*i, 60);
      tick();
    end
    clear_inputs();
    total++; if (o_alloc_tag !== 8'h98) begin bad++; $display("[TB] FAIL fa_pre_tag got=%h want=98", o_alloc_tag); end
    i_flush_valid = 1'b1;
    i_flush_tag   = 4'd5;
    drive_alloc(8, 70);
    drive_cdb(2'b01, 0, 6);
    tick();
    clear_inputs();
    total++; if (o_count !== 5'd6) begin bad++; $display("[TB] FAIL fa_count got=%0d want=6", o_count); end
    total++; if (o_alloc_tag !== 8'h76) begin bad++; $display("[TB] FAIL fa_atag got=%h want=76", o_alloc_tag); end
    drive_cdb(2'b11, 1, 0);
    tick();
    clear_inputs();
    total++; if (o_commit_valid !== 2'b11 || o_commit_old_preg !== {7'd61, 7'd60}) begin
      bad++; $display("[TB] FAIL fa_commit got=%b/%h want=11/%h", o_commit_valid, o_commit_old_preg, {7'd61, 7'd60});
    end
  endtask

  task automatic test_flush_invalid();
    i_flush_valid = 1'b1;
    i_flush_tag   = 4'd10;
    tick();
    clear_inputs();
    total++; if (o_count !== 5'd4) begin bad++; $display("[TB] FAIL fi_count got=%0d want=4", o_count); end
    total++; if (o_alloc_tag !== 8'h76) begin bad++; $display("[TB] FAIL fi_atag got=%h want=76", o_alloc_tag); end
    total++; if (o_commit_tag !== 8'h32) begin bad++; $display("[TB] FAIL fi_ctag got=%h want=32", o_commit_tag); end
    i_flush_valid = 1'b1;
    i_flush_tag   = 4'd3;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    clear_inputs();
    total++; if (o_count !== 5'd0 || o_empty !== 1'b1) begin bad++; $display("[TB] FAIL rf_state got=%0d/%b want=0/1", o_count, o_empty); end
    total++; if (o_alloc_tag !== 8'h10 || o_alloc_ready !== 1'b1) begin
      bad++; $display("[TB] FAIL rf_alloc got=%h/%b want=10/1", o_alloc_tag, o_alloc_ready);
    end
    total++; if (o_commit_valid !== 2'b00 || o_commit_tag !== 8'h10) begin
      bad++; $display("[TB] FAIL rf_commit got=%b/%h want=00/10", o_commit_valid, o_commit_tag);
    end
  endtask

  initial begin
    reset = 1'b1;
    clear_inputs();
    test_reset();
    test_fill();
    test_commit();
    test_wrap();
    test_flush_commit();
    test_flush_alloc_cdb();
    test_flush_invalid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rob_multi.md
Name: rob_multi

Overview:
- Multi-issue reorder buffer. Successor to the single-port ROB.
- Allocates tags internally from a tail pointer, with up to DISP_W entries per cycle.
- Accepts NUM_CDB completion broadcasts per cycle and retires up to COMMIT_W entries per cycle in order.
- Recovers from a mispredict by squashing only the entries younger than the mispredicted branch. Older work and the head are preserved.
- Sits between dispatch/rename and the architectural free-list/commit logic.

Parameters:
- ROB_WIDTH, 4: log2 of entry count; ROB_SIZE = 2**ROB_WIDTH.
- PREG_WIDTH, 7: physical register index width.
- DISP_W, 2: allocation slots per cycle (1..4).
- COMMIT_W, 2: commit slots per cycle (1..4).
- NUM_CDB, 2: completion broadcast ports.

Ports:
- clk  in  1  clock
- reset  in  1  reset
- i_alloc_valid  in  DISP_W  per-slot allocate request; must be contiguous from slot 0
- i_alloc_old_prd  in  DISP_W*PREG_WIDTH  previous preg mapping per slot
- i_alloc_is_branch  in  DISP_W  slot holds a branch
- i_alloc_pc  in  DISP_W*32  PC per slot
- o_alloc_ready  out  1  free entries >= DISP_W
- o_alloc_tag  out  DISP_W*ROB_WIDTH  tag slot k will receive = tail+k (mod ROB_SIZE)
- i_cdb_valid  in  NUM_CDB  completion valid per port
- i_cdb_tag  in  NUM_CDB*ROB_WIDTH  completing entry tag
- o_commit_valid  out  COMMIT_W  per-slot commit, contiguous from slot 0
- o_commit_old_preg  out  COMMIT_W*PREG_WIDTH  preg to free per slot
- o_commit_tag  out  COMMIT_W*ROB_WIDTH  head+k
- o_commit_pc  out  COMMIT_W*32  committed PC
- i_flush_valid  in  1  mispredict recovery
- i_flush_tag  in  ROB_WIDTH  tag of mispredicted branch; it survives, entries younger are squashed
- o_count  out  ROB_WIDTH+1  occupied entries
- o_empty  out  1  count==0

Behaviour:
- Reset is synchronous and active-high on clk. It sets head=tail=0, count=0, and clears every entry's valid/done bits.
- After reset: o_alloc_ready=1, o_empty=1, o_count=0, o_commit_valid=0. o_alloc_tag slot k=k. o_commit_tag slot k=k.
- Allocation is all-or-nothing. The group is accepted when o_alloc_ready && !i_flush_valid.
  - Slot k writes entry tail+k with valid=1, done=0.
  - tail advances by popcount(i_alloc_valid), wrapping mod ROB_SIZE.
  - When not ready, all requests are dropped; no partial accept.
- Completion: each CDB port with valid set and a currently valid target sets done=1 at the clock edge.
  - A CDB to an invalid entry is ignored.
  - Duplicate tags across ports are harmless.
  - A CDB to an entry allocated in the same cycle is ignored. Completion requires the entry to have been allocated on an earlier cycle.
- Commit is combinational from registered state, with no back-pressure.
  - Slot k is valid iff slots 0..k-1 are valid, k < count, and entry head+k is valid && done.
  - On the edge, committed entries clear valid and head advances by the number committed.
- count_next = count + accepted_allocs - commits. It never exceeds ROB_SIZE and never goes below 0.
- Flush (i_flush_valid with entry i_flush_tag valid):
  - Allocation is suppressed that cycle; commits still occur.
  - Every entry strictly younger than i_flush_tag, up to tail, clears valid/done.
  - tail <= i_flush_tag+1.
  - count <= ((i_flush_tag - head) mod ROB_SIZE) + 1 - commits.
  - If the flush tag entry is not valid, the flush is ignored.
- Flush vs CDB in the same cycle: squashed entries end invalid and done=0. Surviving entries take their CDB updates.
- Wrap-around: all pointer arithmetic is ROB_WIDTH bits, modulo. Full vs empty is distinguished only by count.
- When full (count==ROB_SIZE), o_alloc_ready=0. Commits that cycle free entries for the next cycle, not the current one.

Test Plan:
- Reset, then 2-wide alloc for 8 cycles at ROB_SIZE=16 -> tags 0..15 assigned; o_count=16; o_alloc_ready=0 from count 15 onward; further requests dropped.
- CDB tags 1 and 0 in one cycle -> next cycle o_commit_valid=2'b11, tags 0/1 with correct old_preg; tag 1 done while tag 0 not done -> no commit.
- Head at 14, allocate 4 entries -> tags 14,15,0,1; complete all; commit over two cycles -> head=2, o_empty=1.
- Entries 0..9 valid, flush_tag=4 with commit of tag 0 in the same cycle -> count=4, tail=5; next o_alloc_tag={6,5}; CDB to tag 7 next cycle ignored.
- Flush, 2-wide alloc and CDB to tag 6 all in one cycle (tail=8, flush_tag=5) -> alloc dropped; entry 6 invalid, done=0.
- Flush with invalid tag -> no state change; reset mid-flush -> reset state as specified.
